// File: rtl/intersection_pkg.sv
// Shared types and defaults for the intersection safety monitor.
package intersection_pkg;

  // Violation classes, listed in ascending code order; capture priority is
  // CONFLICT > CLEARANCE > MIN_GREEN > STARVE.
  typedef enum logic [2:0] {
    NONE      = 3'd0,
    CONFLICT  = 3'd1,
    CLEARANCE = 3'd2,
    MIN_GREEN = 3'd3,
    STARVE    = 3'd4
  } violation_e;

  localparam int DEFAULT_NUM_PHASES = 4;

  typedef logic [$clog2(DEFAULT_NUM_PHASES)-1:0] phase_idx_t;

  // Phases: 0 = ped, 1 = up, 2 = down, 3 = turn.
  // The pedestrian phase conflicts with every vehicle phase, and turn
  // conflicts with up and down. Up and down may run together.
  // Only the upper triangle is set; the monitor ORs the matrix with its transpose.
  localparam logic [15:0] DEFAULT_CONFLICT = 16'h088E;

endpackage

// File: rtl/phase_tracker.sv
// Per-phase history: previous green, saturating green run length, saturating
// all-red gap length, latched request and saturating wait counter.
module phase_tracker #(
  parameter int CNT_W        = 7,
  parameter int CLEAR_CYCLES = 2,
  parameter int MIN_GREEN    = 4,
  parameter int MAX_WAIT     = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic green,
  input  logic request,
  output logic rise,
  output logic gap_short,
  output logic min_green_fail,
  output logic starve
);

  localparam logic [CNT_W-1:0] RUN_MAX   = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] GAP_MAX   = CNT_W'(CLEAR_CYCLES);
  localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] STARVE_AT = CNT_W'(MAX_WAIT - 1);

  logic             green_q;
  logic             pending;
  logic [CNT_W-1:0] run;
  logic [CNT_W-1:0] gap;
  logic [CNT_W-1:0] wait_cnt;

  // Counter state; gap starts saturated so the first green after reset is not a clearance fault.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      green_q  <= 1'b0;
      run      <= '0;
      gap      <= GAP_MAX;
      pending  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      green_q  <= green;
      run      <= green ? ((run < RUN_MAX) ? run + 1'b1 : run) : '0;
      gap      <= green ? '0 : ((gap < GAP_MAX) ? gap + 1'b1 : gap);
      pending  <= green ? 1'b0 : (pending | request);
      wait_cnt <= (pending && !green) ?
                  ((wait_cnt < WAIT_MAX) ? wait_cnt + 1'b1 : wait_cnt) : '0;
    end
  end

  assign rise           = green & ~green_q;
  assign gap_short      = (gap < GAP_MAX);
  assign min_green_fail = green_q & ~green & (run < RUN_MAX);
  assign starve         = pending & ~green & (wait_cnt == STARVE_AT);

endmodule

// File: rtl/intersection_monitor.sv
// Runtime safety monitor for an N-phase signalised intersection: checks
// pairwise conflicts, all-red clearance, minimum green and request starvation,
// then latches the first fault and drives an all-red override.
module intersection_monitor #(
  parameter int                                   NUM_PHASES   = 4,
  parameter logic [NUM_PHASES*NUM_PHASES-1:0]     CONFLICT     = intersection_pkg::DEFAULT_CONFLICT,
  parameter int                                   CLEAR_CYCLES = 2,
  parameter int                                   MIN_GREEN    = 4,
  parameter int                                   MAX_WAIT     = 64,
  parameter int                                   CNT_W        = $clog2(MAX_WAIT + 1),
  localparam int                                  PW           = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_PHASES-1:0] green,
  input  logic [NUM_PHASES-1:0] request,
  input  logic                  clear,
  output logic                  fail,
  output logic                  fail_pulse,
  output logic [2:0]            fail_code,
  output logic [PW-1:0]         fail_phase,
  output logic                  all_red
);

  logic [NUM_PHASES-1:0] rise;
  logic [NUM_PHASES-1:0] gap_short;
  logic [NUM_PHASES-1:0] min_green_vec;
  logic [NUM_PHASES-1:0] starve_vec;
  logic [NUM_PHASES-1:0] conflict_vec;
  logic [NUM_PHASES-1:0] clearance_vec;

  intersection_pkg::violation_e new_code;
  logic [PW-1:0]                new_phase;
  logic                         any_violation;
  logic                         fail_next;

  for (genvar p = 0; p < NUM_PHASES; p++) begin : g_phase
    phase_tracker #(
      .CNT_W        (CNT_W),
      .CLEAR_CYCLES (CLEAR_CYCLES),
      .MIN_GREEN    (MIN_GREEN),
      .MAX_WAIT     (MAX_WAIT)
    ) u_tracker (
      .clock          (clock),
      .reset          (reset),
      .green          (green[p]),
      .request        (request[p]),
      .rise           (rise[p]),
      .gap_short      (gap_short[p]),
      .min_green_fail (min_green_vec[p]),
      .starve         (starve_vec[p])
    );
  end

  // Pairwise checks over the symmetric conflict matrix; a phase is flagged for each partner it violates against.
  always_comb begin
    conflict_vec  = '0;
    clearance_vec = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      for (int j = 0; j < NUM_PHASES; j++) begin
        if (i != j && (CONFLICT[i*NUM_PHASES+j] || CONFLICT[j*NUM_PHASES+i])) begin
          if (green[i] && green[j])
            conflict_vec[i] = 1'b1;
          if (rise[i] && !green[j] && gap_short[j])
            clearance_vec[i] = 1'b1;
        end
      end
    end
  end

  // Priority encoder: later loops override earlier ones, and descending index leaves the lowest phase.
  always_comb begin
    new_code  = intersection_pkg::NONE;
    new_phase = '0;
    for (int i = NUM_PHASES - 1; i >= 0; i--)
      if (starve_vec[i]) begin
        new_code  = intersection_pkg::STARVE;
        new_phase = PW'(i);
      end
    for (int i = NUM_PHASES - 1; i >= 0; i--)
      if (min_green_vec[i]) begin
        new_code  = intersection_pkg::MIN_GREEN;
        new_phase = PW'(i);
      end
    for (int i = NUM_PHASES - 1; i >= 0; i--)
      if (clearance_vec[i]) begin
        new_code  = intersection_pkg::CLEARANCE;
        new_phase = PW'(i);
      end
    for (int i = NUM_PHASES - 1; i >= 0; i--)
      if (conflict_vec[i]) begin
        new_code  = intersection_pkg::CONFLICT;
        new_phase = PW'(i);
      end
  end

  assign any_violation = |{conflict_vec, clearance_vec, min_green_vec, starve_vec};
  assign fail_next     = any_violation | (fail & ~clear);

  // Sticky fail with first-fault capture; a violation in the same cycle as clear wins and is captured fresh.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fail       <= 1'b0;
      fail_pulse <= 1'b0;
      fail_code  <= intersection_pkg::NONE;
      fail_phase <= '0;
      all_red    <= 1'b0;
    end else begin
      fail       <= fail_next;
      all_red    <= fail_next;
      fail_pulse <= any_violation;
      if (any_violation && (!fail || clear)) begin
        fail_code  <= new_code;
        fail_phase <= new_phase;
      end else if (clear && !any_violation) begin
        fail_code  <= intersection_pkg::NONE;
        fail_phase <= '0;
      end
    end
  end

endmodule

// File: tb/tb_intersection_monitor.sv
// Directed bench for intersection_monitor: reset, conflict, clearance,
// minimum green, starvation with clear, and clear/reset interaction.
module tb_intersection_monitor;

  localparam logic [2:0] C_NONE      = 3'd0;
  localparam logic [2:0] C_CONFLICT  = 3'd1;
  localparam logic [2:0] C_CLEARANCE = 3'd2;
  localparam logic [2:0] C_MIN_GREEN = 3'd3;
  localparam logic [2:0] C_STARVE    = 3'd4;

  logic       clock;
  logic       reset;
  logic [3:0] green;
  logic [3:0] request;
  logic       clear;
  logic       fail;
  logic       fail_pulse;
  logic [2:0] fail_code;
  logic [1:0] fail_phase;
  logic       all_red;

  int n_checks = 0;
  int n_fail   = 0;

  intersection_monitor #(
    .NUM_PHASES   (4),
    .CONFLICT     (16'h088E),
    .CLEAR_CYCLES (2),
    .MIN_GREEN    (4),
    .MAX_WAIT     (64)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .green      (green),
    .request    (request),
    .clear      (clear),
    .fail       (fail),
    .fail_pulse (fail_pulse),
    .fail_code  (fail_code),
    .fail_phase (fail_phase),
    .all_red    (all_red)
  );

  // Free-running 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, let the DUT sample them, land 1 ns past the edge.
  task automatic apply_stimulus(input logic [3:0] g, input logic [3:0] r, input logic c);
    green   = g;
    request = r;
    clear   = c;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++)
      apply_stimulus(4'b0000, 4'b0000, 1'b0);
  endtask

  task automatic check_all(input string tag, input logic f, input logic p,
                           input logic [2:0] code, input logic [1:0] ph);
    check_output({tag, "_fail"}, 32'(fail), 32'(f));
    check_output({tag, "_pulse"}, 32'(fail_pulse), 32'(p));
    check_output({tag, "_code"}, 32'(fail_code), 32'(code));
    check_output({tag, "_phase"}, 32'(fail_phase), 32'(ph));
    check_output({tag, "_all_red"}, 32'(all_red), 32'(f));
  endtask

  initial begin
    int bad_cycles;
    int first_pulse;
    int extra_pulses;

    reset   = 1'b0;
    green   = '0;
    request = '0;
    clear   = 1'b0;

    // T1: reset, then 100 quiet cycles
    repeat (3) @(posedge clock);
    #1;
    check_all("reset", 1'b0, 1'b0, C_NONE, 2'd0);
    reset = 1'b1;
    bad_cycles = 0;
    for (int k = 0; k < 100; k++) begin
      apply_stimulus(4'b0000, 4'b0000, 1'b0);
      if (fail !== 1'b0 || all_red !== 1'b0) bad_cycles++;
    end
    check_output("t1_quiet_cycles", 32'(bad_cycles), 32'd0);

    // T2: up+down together is legal, ped+down conflicts
    for (int k = 0; k < 10; k++)
      apply_stimulus(4'b0110, 4'b0000, 1'b0);
    check_output("t2_updown_ok", 32'(fail), 32'd0);
    apply_stimulus(4'b0101, 4'b0000, 1'b0);
    check_all("t2_conflict", 1'b1, 1'b1, C_CONFLICT, 2'd0);
    idle(3);
    check_output("t2_sticky_code", 32'(fail_code), 32'(C_CONFLICT));
    check_output("t2_sticky_fail", 32'(fail), 32'd1);
    apply_stimulus(4'b0000, 4'b0000, 1'b1);
    check_all("t2_cleared", 1'b0, 1'b0, C_NONE, 2'd0);
    idle(3);

    // T3a: down 0-5, low at 6, turn rises at 7 -> clearance on turn
    for (int k = 0; k < 6; k++)
      apply_stimulus(4'b0100, 4'b0000, 1'b0);
    apply_stimulus(4'b0000, 4'b0000, 1'b0);
    check_output("t3_down_drop_ok", 32'(fail), 32'd0);
    apply_stimulus(4'b1000, 4'b0000, 1'b0);
    check_all("t3_clearance", 1'b1, 1'b1, C_CLEARANCE, 2'd3);
    for (int k = 0; k < 4; k++)
      apply_stimulus(4'b1000, 4'b0000, 1'b0);
    idle(3);
    apply_stimulus(4'b0000, 4'b0000, 1'b1);
    check_output("t3_cleared", 32'(fail), 32'd0);
    idle(2);

    // T3b: same but turn rises at 8 -> gap reached 2, no fault
    for (int k = 0; k < 6; k++)
      apply_stimulus(4'b0100, 4'b0000, 1'b0);
    idle(2);
    apply_stimulus(4'b1000, 4'b0000, 1'b0);
    check_output("t3_gap_ok", 32'(fail), 32'd0);
    for (int k = 0; k < 4; k++)
      apply_stimulus(4'b1000, 4'b0000, 1'b0);
    apply_stimulus(4'b0000, 4'b0000, 1'b0);
    check_output("t3_turn_drop_ok", 32'(fail), 32'd0);
    idle(3);

    // T4: ped green 3 cycles -> min green fault, then 4 cycles -> clean
    for (int k = 0; k < 3; k++)
      apply_stimulus(4'b0001, 4'b0000, 1'b0);
    apply_stimulus(4'b0000, 4'b0000, 1'b0);
    check_all("t4_min_green", 1'b1, 1'b1, C_MIN_GREEN, 2'd0);
    idle(2);
    apply_stimulus(4'b0000, 4'b0000, 1'b1);
    check_output("t4_cleared", 32'(fail), 32'd0);
    idle(2);
    for (int k = 0; k < 4; k++)
      apply_stimulus(4'b0001, 4'b0000, 1'b0);
    apply_stimulus(4'b0000, 4'b0000, 1'b0);
    check_all("t4_clean", 1'b0, 1'b0, C_NONE, 2'd0);
    idle(3);

    // T5: one request pulse on turn, never served -> one starvation flag
    apply_stimulus(4'b0000, 4'b1000, 1'b0);
    first_pulse = 0;
    for (int n = 1; n <= 100 && first_pulse == 0; n++) begin
      apply_stimulus(4'b0000, 4'b0000, 1'b0);
      if (fail_pulse === 1'b1) begin
        first_pulse = n;
        check_all("t5_starve", 1'b1, 1'b1, C_STARVE, 2'd3);
      end
    end
    check_output("t5_starve_cycle", 32'(first_pulse), 32'd64);
    apply_stimulus(4'b0000, 4'b0000, 1'b1);
    check_all("t5_cleared", 1'b0, 1'b0, C_NONE, 2'd0);
    extra_pulses = 0;
    for (int k = 0; k < 60; k++) begin
      apply_stimulus(4'b0000, 4'b0000, 1'b0);
      if (fail_pulse !== 1'b0 || fail !== 1'b0) extra_pulses++;
    end
    check_output("t5_no_reflag", 32'(extra_pulses), 32'd0);

    // T6: first fault min green on up, then clearance (held), then clear with conflict
    apply_stimulus(4'b0010, 4'b0000, 1'b0);
    apply_stimulus(4'b0010, 4'b0000, 1'b0);
    apply_stimulus(4'b0000, 4'b0000, 1'b0);
    check_all("t6_first", 1'b1, 1'b1, C_MIN_GREEN, 2'd1);
    apply_stimulus(4'b0001, 4'b0000, 1'b0);
    check_all("t6_held", 1'b1, 1'b1, C_MIN_GREEN, 2'd1);
    apply_stimulus(4'b1100, 4'b0000, 1'b1);
    check_all("t6_clear_vs_fault", 1'b1, 1'b1, C_CONFLICT, 2'd2);

    // Asynchronous reset in the middle of a cycle
    #2;
    reset = 1'b0;
    #1;
    check_all("t6_async_reset", 1'b0, 1'b0, C_NONE, 2'd0);
    green = '0;
    @(posedge clock);
    #3;
    reset = 1'b1;
    idle(5);
    check_all("t6_after_reset", 1'b0, 1'b0, C_NONE, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
